// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-outstanding instruction read and a 2-entry
// {pc, instr} buffer feeding decode. A redirect flushes the buffer. A redirect
// that arrives while a read is still pending waits in DRAIN for that response,
// then discards it.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating performance counters.
// perf_wait_o counts cycles spent waiting on memValid1. perf_fetched_o counts pushes.
// Without the macro both outputs are tied to zero and no counter flops exist.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        MEM_CLK,
  input  logic        RST,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        dec_ready_i,
  output logic        MEM_RDEN1,
  output logic [13:0] MEM_ADDR1,
  input  logic [31:0] MEM_DOUT1,
  input  logic        memValid1,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic [31:0] perf_wait_o,
  output logic [31:0] perf_fetched_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        rden_q;

  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic [31:0] e0_pc_q, e0_instr_q;
  logic [31:0] e1_pc_q, e1_instr_q;

  logic        push;
  logic        pop;
  logic        wr_second;
  logic [31:0] redir_pc;

  // Instruction addresses are word aligned; the low redirect bits are dropped.
  assign redir_pc = {redirect_pc_i[31:2], 2'b00};
  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^redirect_pc_i[1:0];

  // Buffer control: redirect overrides both push and pop in the same cycle.
  always_comb begin
    push      = (state_q == StFetch) && memValid1 && !redirect_i;
    pop       = (count_q != 2'd0) && dec_ready_i && !redirect_i;
    count_d   = count_q;
    if (redirect_i) begin
      count_d = 2'd0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
    // A push goes to the second slot only when the head stays occupied.
    wr_second = (count_q == 2'd1) && !pop;
  end

  // Shift-style FIFO. Entry 0 is always the head.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      count_q    <= 2'd0;
      e0_pc_q    <= '0;
      e0_instr_q <= '0;
      e1_pc_q    <= '0;
      e1_instr_q <= '0;
    end else begin
      count_q <= count_d;
      if (pop) begin
        e0_pc_q    <= e1_pc_q;
        e0_instr_q <= e1_instr_q;
      end
      // On push+pop with one entry, this write overrides the shift above.
      if (push) begin
        if (wr_second) begin
          e1_pc_q    <= pc_q;
          e1_instr_q <= MEM_DOUT1;
        end else begin
          e0_pc_q    <= pc_q;
          e0_instr_q <= MEM_DOUT1;
        end
      end
    end
  end

  // Fetch FSM: owns pc, latched redirect target and the registered read enable.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      rden_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (redirect_i) begin
            pc_q <= redir_pc;
          end
          state_q <= StFetch;
          rden_q  <= 1'b1;
        end
        StFetch: begin
          if (redirect_i && !memValid1) begin
            // The read is still in flight; its response must be swallowed first.
            tgt_q   <= redir_pc;
            state_q <= StDrain;
            rden_q  <= 1'b1;
          end else if (redirect_i) begin
            pc_q    <= redir_pc;
            state_q <= StFetch;
            rden_q  <= 1'b1;
          end else if (memValid1) begin
            pc_q <= pc_q + 32'd4;
            if (count_d == 2'd2) begin
              state_q <= StHold;
              rden_q  <= 1'b0;
            end
          end
        end
        StHold: begin
          if (redirect_i) begin
            pc_q    <= redir_pc;
            state_q <= StFetch;
            rden_q  <= 1'b1;
          end else if (count_d != 2'd2) begin
            state_q <= StFetch;
            rden_q  <= 1'b1;
          end
        end
        StDrain: begin
          // A redirect in the same cycle as the response still wins.
          if (redirect_i) begin
            tgt_q <= redir_pc;
          end
          if (memValid1) begin
            pc_q    <= redirect_i ? redir_pc : tgt_q;
            state_q <= StFetch;
            rden_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rden_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_RDEN1     = rden_q;
  assign MEM_ADDR1     = pc_q[15:2];
  assign instr_valid_o = (count_q != 2'd0);
  assign instr_o       = instr_valid_o ? e0_instr_q : '0;
  assign pc_o          = instr_valid_o ? e0_pc_q : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_wait_q;
  logic [31:0] perf_fetched_q;

  // Saturating counters for memory wait cycles and accepted instructions.
  always_ff @(posedge MEM_CLK or posedge RST) begin
    if (RST) begin
      perf_wait_q    <= '0;
      perf_fetched_q <= '0;
    end else begin
      if ((state_q == StFetch || state_q == StDrain) && !memValid1 &&
          perf_wait_q != 32'hFFFF_FFFF) begin
        perf_wait_q <= perf_wait_q + 32'd1;
      end
      if (push && perf_fetched_q != 32'hFFFF_FFFF) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
    end
  end

  assign perf_wait_o    = perf_wait_q;
  assign perf_fetched_o = perf_fetched_q;
`else
  assign perf_wait_o    = '0;
  assign perf_fetched_o = '0;
`endif

  // Structural invariants of the buffer/FSM pairing.
  a_count_range : assert property (@(posedge MEM_CLK) disable iff (RST) count_q <= 2'd2);
  a_hold_full   : assert property (@(posedge MEM_CLK) disable iff (RST)
                                   state_q == StHold |-> count_q == 2'd2);
  a_drain_empty : assert property (@(posedge MEM_CLK) disable iff (RST)
                                   state_q == StDrain |-> count_q == 2'd0);

endmodule
